// File: rtl/interboard_pkg.sv
// interboard_pkg
// Shared definitions for the inter-board serial link: frame length, the
// transmitter FSM state encoding, the message type codes that the game FSM
// and this link both use, and the parity/frame helpers.
package interboard_pkg;

    localparam int FRAME_BITS = 11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SHIFT    = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_DONE     = 3'd3,
        ST_FAIL     = 3'd4
    } tx_state_e;

    // Message type codes carried in the 3-bit type field.
    localparam logic [2:0] STATE_TURN = 3'd1;
    localparam logic [2:0] SEL_NUM    = 3'd2;
    localparam logic [2:0] STATE_WIN  = 3'd3;

    typedef struct packed {
        logic [2:0] msg_type;
        logic [4:0] number;
    } msg_t;

    // Even parity: the parity bit equals the XOR of the data bits.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

    // Frame bit k is the k-th bit on the wire: start, type LSB first,
    // number LSB first, parity, stop.
    function automatic logic [FRAME_BITS-1:0] build_frame(input msg_t msg);
        return {1'b1, even_parity({msg.number, msg.msg_type}),
                msg.number, msg.msg_type, 1'b0};
    endfunction

endpackage

// File: rtl/interboard_tx_if.sv
// interboard_tx_if
// Request/status bundle between the game controller (master) and the
// inter-board transmitter (slave).
//   transmit, ctrl_en, ctrl_msg_type, ctrl_number : master -> slave
//   inter_ready, busy, tx_fail, overflow          : slave -> master
interface interboard_tx_if;

    logic       transmit;
    logic       ctrl_en;
    logic [2:0] ctrl_msg_type;
    logic [4:0] ctrl_number;
    logic       inter_ready;
    logic       busy;
    logic       tx_fail;
    logic       overflow;

    modport master (
        output transmit, ctrl_en, ctrl_msg_type, ctrl_number,
        input  inter_ready, busy, tx_fail, overflow
    );

    modport slave (
        input  transmit, ctrl_en, ctrl_msg_type, ctrl_number,
        output inter_ready, busy, tx_fail, overflow
    );

endinterface

// File: rtl/interboard_tx_ack_sync.sv
// ack_sync
// Two-flop synchroniser for an asynchronous level plus a rising-edge
// detector; shared with the inter-board receiver.
//   clk, rst : clock and synchronous active-high reset
//   async_in : asynchronous input level
//   rise     : one-cycle pulse on a synchronised rising edge
module ack_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic meta_r;
    logic sync_r;
    logic prev_r;

    // Synchroniser chain plus the delayed copy used for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
            prev_r <= 1'b0;
        end else begin
            meta_r <= async_in;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign rise = sync_r & ~prev_r;

endmodule

// File: rtl/interboard_tx.sv
// interboard_tx
// Serialises one {type, number} message per accepted request into an
// 11-bit framed, parity-protected word, waits for the peer acknowledge,
// retries on timeout and reports success (inter_ready) or failure (tx_fail).
// A single-entry holding buffer absorbs one request while busy.
//   clk, rst        : clock and synchronous active-high reset
//   interboard_rst  : peer-initiated reset, same effect as rst
//   peer_ack        : asynchronous acknowledge from the peer (rising edge)
//   tx_line         : serial output, idles high
//   ctrl            : request/status bundle (slave side)
module interboard_tx
    import interboard_pkg::*;
#(
    parameter int BIT_CYCLES  = 16,
    parameter int ACK_TIMEOUT = 4096,
    parameter int MAX_RETRY   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             interboard_rst,
    input  logic             peer_ack,
    output logic             tx_line,
    interboard_tx_if.slave   ctrl
);

    localparam int CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);
    localparam logic [CYC_W-1:0] CYC_ZERO = CYC_W'(0);
    localparam logic [CYC_W-1:0] CYC_ONE  = CYC_W'(1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_ZERO = TMO_W'(0);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
    localparam logic [RTY_W-1:0] RTY_ZERO = RTY_W'(0);
    localparam logic [RTY_W-1:0] RTY_ONE  = RTY_W'(1);
    localparam logic [3:0]       BIT_LAST = 4'(FRAME_BITS - 1);

    tx_state_e               state_r;
    logic [FRAME_BITS-1:0]   frame_r;
    logic [FRAME_BITS-1:0]   buf_frame_r;
    logic                    buf_valid_r;
    logic [3:0]              bit_cnt_r;
    logic [CYC_W-1:0]        cyc_cnt_r;
    logic [TMO_W-1:0]        tmo_cnt_r;
    logic [RTY_W-1:0]        retry_cnt_r;
    logic                    tx_line_r;
    logic                    inter_ready_r;
    logic                    busy_r;
    logic                    tx_fail_r;
    logic                    overflow_r;

    logic                    reset_s;
    logic                    ack_rise_s;
    logic                    accept_s;
    msg_t                    req_msg_s;
    logic [FRAME_BITS-1:0]   req_frame_s;
    logic [FRAME_BITS-1:0]   launch_frame_s;
    logic                    launch_direct_s;
    logic                    launch_buf_s;
    logic                    launch_s;
    logic                    store_s;
    logic                    drop_s;
    logic [3:0]              next_bit_s;

    assign reset_s     = rst | interboard_rst;
    assign accept_s    = ctrl.ctrl_en & ctrl.transmit;
    assign req_msg_s   = {ctrl.ctrl_msg_type, ctrl.ctrl_number};
    assign req_frame_s = build_frame(req_msg_s);
    assign next_bit_s  = bit_cnt_r + 4'd1;

    ack_sync u_ack_sync (
        .clk      (clk),
        .rst      (reset_s),
        .async_in (peer_ack),
        .rise     (ack_rise_s)
    );

    // Decide whether a frame launches this cycle and what happens to a request.
    always_comb begin
        launch_direct_s = 1'b0;
        launch_buf_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (buf_valid_r) begin
                    launch_buf_s = 1'b1;
                end else if (accept_s) begin
                    launch_direct_s = 1'b1;
                end else begin
                    launch_direct_s = 1'b0;
                end
            end
            ST_DONE, ST_FAIL: begin
                if (buf_valid_r) begin
                    launch_buf_s = 1'b1;
                end else begin
                    launch_buf_s = 1'b0;
                end
            end
            default: begin
                launch_direct_s = 1'b0;
                launch_buf_s    = 1'b0;
            end
        endcase
        launch_s       = launch_direct_s | launch_buf_s;
        launch_frame_s = launch_buf_s ? buf_frame_r : req_frame_s;
        // The buffer slot is free if empty or being drained this very cycle.
        store_s = accept_s & ~launch_direct_s & (~buf_valid_r | launch_buf_s);
        drop_s  = accept_s & ~launch_direct_s & buf_valid_r & ~launch_buf_s;
    end

    // Transmitter FSM, holding buffer and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset_s) begin
            state_r       <= ST_IDLE;
            frame_r       <= {FRAME_BITS{1'b1}};
            buf_frame_r   <= {FRAME_BITS{1'b1}};
            buf_valid_r   <= 1'b0;
            bit_cnt_r     <= 4'd0;
            cyc_cnt_r     <= CYC_ZERO;
            tmo_cnt_r     <= TMO_ZERO;
            retry_cnt_r   <= RTY_ZERO;
            tx_line_r     <= 1'b1;
            inter_ready_r <= 1'b0;
            busy_r        <= 1'b0;
            tx_fail_r     <= 1'b0;
            overflow_r    <= 1'b0;
        end else begin
            inter_ready_r <= 1'b0;
            tx_fail_r     <= 1'b0;

            if (store_s) begin
                buf_frame_r <= req_frame_s;
                buf_valid_r <= 1'b1;
            end else if (launch_buf_s) begin
                buf_valid_r <= 1'b0;
            end

            if (drop_s) begin
                overflow_r <= 1'b1;
            end

            case (state_r)
                ST_IDLE, ST_DONE, ST_FAIL: begin
                    if (launch_s) begin
                        state_r     <= ST_SHIFT;
                        frame_r     <= launch_frame_s;
                        bit_cnt_r   <= 4'd0;
                        cyc_cnt_r   <= CYC_ZERO;
                        retry_cnt_r <= RTY_ZERO;
                        tx_line_r   <= launch_frame_s[0];
                        busy_r      <= 1'b1;
                    end else begin
                        state_r   <= ST_IDLE;
                        tx_line_r <= 1'b1;
                        // A request taken during DONE/FAIL keeps busy up.
                        busy_r    <= store_s;
                    end
                end
                ST_SHIFT: begin
                    if (cyc_cnt_r == CYC_LAST) begin
                        cyc_cnt_r <= CYC_ZERO;
                        if (bit_cnt_r == BIT_LAST) begin
                            state_r   <= ST_WAIT_ACK;
                            tmo_cnt_r <= TMO_ZERO;
                            tx_line_r <= 1'b1;
                        end else begin
                            bit_cnt_r <= next_bit_s;
                            tx_line_r <= frame_r[next_bit_s];
                        end
                    end else begin
                        cyc_cnt_r <= cyc_cnt_r + CYC_ONE;
                    end
                end
                ST_WAIT_ACK: begin
                    if (ack_rise_s) begin
                        state_r       <= ST_DONE;
                        inter_ready_r <= 1'b1;
                    end else if (tmo_cnt_r == TMO_LAST) begin
                        if (retry_cnt_r < RTY_MAX) begin
                            retry_cnt_r <= retry_cnt_r + RTY_ONE;
                            state_r     <= ST_SHIFT;
                            bit_cnt_r   <= 4'd0;
                            cyc_cnt_r   <= CYC_ZERO;
                            tx_line_r   <= frame_r[0];
                        end else begin
                            state_r   <= ST_FAIL;
                            tx_fail_r <= 1'b1;
                        end
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    tx_line_r <= 1'b1;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign tx_line          = tx_line_r;
    assign ctrl.inter_ready = inter_ready_r;
    assign ctrl.busy        = busy_r;
    assign ctrl.tx_fail     = tx_fail_r;
    assign ctrl.overflow    = overflow_r;

endmodule

// File: doc/interboard_tx.md
# interboard_tx

Serial transmitter between the master game controller and the peer board. It accepts one message per `ctrl_en` pulse (3-bit message type plus 5-bit number) and serialises it onto a single wire as a framed, parity-protected word. It then waits for the peer's acknowledge and returns a one-cycle `inter_ready` pulse, which the game FSM uses to leave its SEND states. Timeouts trigger automatic retransmission, with a failure pulse once retries are exhausted.

## Interface
- `BIT_CYCLES`, default 16: clocks per serial bit (≥2).
- `ACK_TIMEOUT`, default 4096: clocks waited in WAIT_ACK before a retry.
- `MAX_RETRY`, default 3: retransmissions after the first attempt before giving up.

- `clk` input 1: system clock.
- `rst` input 1: reset, synchronous, active-high.
- `interboard_rst` input 1: peer-initiated reset, synchronous, active-high. Same effect as `rst`.
- `transmit` input 1: gate. A `ctrl_en` is accepted only while `transmit` is 1.
- `ctrl_en` input 1: one-cycle request to send.
- `ctrl_msg_type` input 3: message type, captured when `ctrl_en` is accepted.
- `ctrl_number` input 5: number payload, captured when `ctrl_en` is accepted.
- `peer_ack` input 1: asynchronous acknowledge from the peer. Its rising edge means the frame was received.
- `tx_line` output 1: serial data, idles high.
- `inter_ready` output 1: one-cycle pulse when the current frame is acknowledged.
- `busy` output 1: high from frame acceptance until completion (ack or fail).
- `tx_fail` output 1: one-cycle pulse when retries are exhausted.
- `overflow` output 1: sticky. Set when a request is dropped; cleared only by reset.

## Operation
- **Frame**: 11 bits, each held for `BIT_CYCLES` clocks, sent in this order:
  - start bit 0;
  - `msg_type[0..2]`, LSB first;
  - `number[0..4]`, LSB first;
  - even parity over the 8 data bits (XOR of the data bits);
  - stop bit 1.
- **FSM states**: IDLE, SHIFT, WAIT_ACK, DONE, FAIL.
  - IDLE → SHIFT on an accepted request, or on a non-empty holding buffer. The frame register is loaded and the retry count cleared.
  - SHIFT uses a bit counter 0..10 and a cycle counter 0..`BIT_CYCLES`-1. After bit 10 completes, go to WAIT_ACK and clear the timeout counter.
  - WAIT_ACK → DONE on a synchronised `peer_ack` rising edge.
  - WAIT_ACK on timeout (`ACK_TIMEOUT` cycles): if retry count < `MAX_RETRY`, increment it and go back to SHIFT with the same frame; otherwise go to FAIL.
  - DONE: `inter_ready`=1 for one cycle, then IDLE.
  - FAIL: `tx_fail`=1 for one cycle, drop the frame, then IDLE.
- **Ack edges** detected outside WAIT_ACK are discarded as stale.
- **Holding buffer** (one entry, used while `busy`):
  - An accepted request is stored if the buffer is empty.
  - If the buffer is full, the request is dropped and `overflow` is set.
  - The buffered frame launches on the cycle after DONE or FAIL.
- A `ctrl_en` in the same cycle as `inter_ready` goes to the buffer.
- `ctrl_en` with `transmit`=0 is ignored and does not set `overflow`.

## Timing
- **Reset values**: `tx_line`=1, `inter_ready`=0, `busy`=0, `tx_fail`=0, `overflow`=0; buffer empty; FSM in IDLE.
- **Reset mid-frame**: `tx_line` is 1 from the next cycle. No `inter_ready` or `tx_fail` pulse is emitted.
- **Start of frame**: `ctrl_en` accepted in IDLE at cycle 0. The start bit appears on `tx_line` at cycle 1. `busy` is high from cycle 1.
- **End of frame**: the stop bit ends at cycle 11·`BIT_CYCLES`. WAIT_ACK is entered at cycle 11·`BIT_CYCLES`+1.
- **Ack path**: `peer_ack` goes through a 2-flop synchroniser plus an edge register. `inter_ready` pulses 3 cycles after `peer_ack` is first sampled high in WAIT_ACK.
- **Retry**: restarts with the start bit on the cycle after the timeout. `tx_line` stays 1 during WAIT_ACK.
- **Completion**: `busy` falls in the cycle after the `inter_ready` or `tx_fail` pulse, unless the buffer is non-empty.

## Structure
- **Shared package `interboard_pkg`**:
  - `FRAME_BITS`=11;
  - state encoding;
  - message type codes STATE_TURN, SEL_NUM, STATE_WIN, so the game FSM and this block share them;
  - parity function.
- **Sub-module `ack_sync`**: 2-flop synchroniser plus rising-edge detector. It is reused by the future receiver.

## Test plan
All scenarios use `BIT_CYCLES`=4 unless noted.
- **Frame format**: `msg_type`=3'b010, `number`=17. `tx_line` bits are 0,0,1,0,1,0,0,0,1,1,1, each held 4 cycles.
- **Ack latency**: ack at cycle 50 → `inter_ready` pulse at cycle 53; `busy` low at 54.
- **Retry and fail**: `ACK_TIMEOUT`=20, `MAX_RETRY`=2, no ack. Exactly 3 identical frames are sent, then one `tx_fail` pulse, no `inter_ready`, and IDLE.
- **Buffering**: second `ctrl_en` (SEL_NUM, 5) mid-frame, third mid-frame. The second frame starts the cycle after the first `inter_ready`; the third is dropped and `overflow`=1.
- **Gating and stale ack**: `ctrl_en` with `transmit`=0 gives no activity. `peer_ack` pulsed during SHIFT is ignored and the block times out normally.
- **Reset mid-frame**: `rst` at bit 5 gives `tx_line`=1 next cycle, `busy`=0, and no pulses. The same check applies to `interboard_rst`.
